imm_table: RTL and testbench

IMM_TABLE -- requirements
Module: imm_table

---
 rtl/imm_table.sv | 155 +++++++++++++++
 tb/tb_imm_table.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_table.sv
// Immediate lookup table: maps word-aligned instruction addresses to stored constants,
// decodes I/J/U/RAW immediates, and keeps saturating hit/miss statistics.
module imm_table #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [1:0]               wr_type,
    input  logic                     req_valid,
    input  logic [31:0]              inst_add,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic                     rsp_miss,
    output logic [1:0]               rsp_type,
    output logic [11:0]              const_12,
    output logic [19:0]              const_20,
    output logic [31:0]              const_32,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    // state | meaning
    // INIT  | sweeping init_idx over all entries, clearing one valid bit per cycle
    // RUN   | accepting writes and lookups
    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   init_idx;

    logic [31:0]        mem_val  [DEPTH];
    logic [1:0]         mem_type [DEPTH];
    logic [DEPTH-1:0]   mem_vld;

    logic               below;
    logic [29:0]        word_off;
    logic               addr_bad;

    logic               s1_valid;
    logic               s1_bad;
    logic [IDX_W-1:0]   s1_idx;

    logic               hit;
    logic [31:0]        ent_val;
    logic [1:0]         ent_type;

    function automatic logic [31:0] decode(input logic [31:0] v, input logic [1:0] t);
        case (t)
            2'd0:    return {{20{v[11]}}, v[11:0]};
            2'd1:    return {{11{v[19]}}, v[19:0], 1'b0};
            2'd2:    return {v[19:0], 12'b0};
            default: return v;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= INIT;
            init_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                init_idx <= init_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_idx == IDX_W'(DEPTH - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    assign req_ready = (state == RUN);

    // Value/type storage carries no reset; entries become usable only once marked valid.
    always_ff @(posedge clk) begin
        if (reset && state == RUN && wr_en) begin
            mem_val[wr_idx]  <= wr_data;
            mem_type[wr_idx] <= wr_type;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == INIT)
                mem_vld[init_idx] <= 1'b0;
            else if (wr_en)
                mem_vld[wr_idx] <= 1'b1;
        end
    end

    // 33-bit subtract: bit 32 flags an address below the table base.
    assign {below, word_off} = 31'(({1'b0, inst_add} - {1'b0, BASE_ADDR}) >> 2);
    assign addr_bad = (inst_add[1:0] != 2'b00) || below || (word_off > 30'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_bad   <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= req_valid && req_ready;
            s1_bad   <= addr_bad;
            s1_idx   <= word_off[IDX_W-1:0];
        end
    end

    // The table is read a cycle after acceptance, so a write in the request cycle is already visible.
    assign ent_val  = mem_val[s1_idx];
    assign ent_type = mem_type[s1_idx];
    assign hit      = !s1_bad && mem_vld[s1_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_miss  <= 1'b0;
            rsp_type  <= 2'd0;
            const_12  <= 12'd0;
            const_20  <= 20'd0;
            const_32  <= 32'd0;
        end else begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_miss <= !hit;
                rsp_type <= hit ? ent_type : 2'd0;
                const_12 <= hit ? ent_val[11:0] : 12'd0;
                const_20 <= hit ? ent_val[19:0] : 20'd0;
                const_32 <= hit ? decode(ent_val, ent_type) : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || cnt_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (s1_valid) begin
            if (hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + 1'b1;
            else if (!hit && miss_cnt != '1)
                miss_cnt <= miss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_table.sv
// Randomized scoreboard bench for imm_table: a table-level reference model predicts each
// response; a monitor compares DUT responses, held outputs, counters and req_ready.
module tb_imm_table;

    localparam int          DEPTH = 64;
    localparam int          IDX_W = 6;
    localparam int          CNT_W = 4;
    localparam int          CMAX  = 15;
    localparam logic [31:0] BASE  = 32'd0;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [31:0]       wr_data;
    logic [1:0]        wr_type;
    logic              req_valid;
    logic [31:0]       inst_add;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_miss;
    logic [1:0]        rsp_type;
    logic [11:0]       const_12;
    logic [19:0]       const_20;
    logic [31:0]       const_32;
    logic              cnt_clr;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    imm_table #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_type(wr_type),
        .req_valid(req_valid), .inst_add(inst_add), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_miss(rsp_miss), .rsp_type(rsp_type),
        .const_12(const_12), .const_20(const_20), .const_32(const_32),
        .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        miss;
        logic [1:0]  typ;
        logic [11:0] c12;
        logic [19:0] c20;
        logic [31:0] c32;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        exp_hold;
    int          checks;
    int          failures;

    logic [31:0] m_val  [DEPTH];
    logic [1:0]  m_type [DEPTH];
    bit          m_vld  [DEPTH];
    int          init_left;
    bit          pend;
    rsp_t        pend_rsp;
    int          m_hit;
    int          m_miss;
    bit          m_ready;
    bit          started;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic rsp_t model_lookup(input logic [31:0] a);
        rsp_t        r;
        int          v;
        int unsigned w;
        r      = '0;
        r.miss = 1'b1;
        if (a % 4 == 0 && a >= BASE) begin
            w = (a - BASE) / 4;
            if (w < DEPTH && m_vld[w]) begin
                r.miss = 1'b0;
                r.typ  = m_type[w];
                r.c12  = 12'(m_val[w] & 32'hFFF);
                r.c20  = 20'(m_val[w] & 32'hFFFFF);
                case (m_type[w])
                    2'd0: begin
                        v = int'(m_val[w] & 32'hFFF);
                        if (v >= 2048) v -= 4096;
                        r.c32 = 32'(v);
                    end
                    2'd1: begin
                        v = int'(m_val[w] & 32'hFFFFF) * 2;
                        if (v >= (1 << 20)) v -= (1 << 21);
                        r.c32 = 32'(v);
                    end
                    2'd2:    r.c32 = (m_val[w] & 32'hFFFFF) * 4096;
                    default: r.c32 = m_val[w];
                endcase
            end
        end
        return r;
    endfunction

    // One clock cycle of stimulus; the model is advanced to the state after the coming edge.
    task automatic step(input bit rst, input bit we, input int widx, input logic [31:0] wd,
                        input logic [1:0] wt, input bit rv, input logic [31:0] addr, input bit clr);
        @(negedge clk);
        reset     = rst;
        wr_en     = we;
        wr_idx    = IDX_W'(widx);
        wr_data   = wd;
        wr_type   = wt;
        req_valid = rv;
        inst_add  = addr;
        cnt_clr   = clr;
        started   = 1'b1;
        if (!rst) begin
            init_left = DEPTH;
            pend      = 1'b0;
            m_hit     = 0;
            m_miss    = 0;
            m_ready   = 1'b0;
            exp_hold  = '0;
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        end else if (init_left > 0) begin
            init_left--;
            m_ready = (init_left == 0);
            if (clr) begin
                m_hit  = 0;
                m_miss = 0;
            end
        end else begin
            if (pend) begin
                exp_q.push_back(pend_rsp);
                exp_hold = pend_rsp;
                if (pend_rsp.miss && m_miss < CMAX) m_miss++;
                if (!pend_rsp.miss && m_hit < CMAX) m_hit++;
            end
            if (clr) begin
                m_hit  = 0;
                m_miss = 0;
            end
            pend = 1'b0;
            if (we) begin
                m_val[widx]  = wd;
                m_type[widx] = wt;
                m_vld[widx]  = 1'b1;
            end
            if (rv) begin
                pend     = 1'b1;
                pend_rsp = model_lookup(addr);
            end
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 32'd0, 2'd0, 0, 32'd0, 0);
    endtask

    task automatic wr(input int idx, input logic [31:0] d, input logic [1:0] t);
        step(1, 1, idx, d, t, 0, 32'd0, 0);
    endtask

    task automatic rq(input logic [31:0] a);
        step(1, 0, 0, 32'd0, 2'd0, 1, a, 0);
    endtask

    initial begin
        rsp_t r;
        forever begin
            @(posedge clk);
            #2;
            if (started) begin
                chk("req_ready", 32'(req_ready), 32'(m_ready));
                chk("hit_cnt", 32'(hit_cnt), 32'(m_hit));
                chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
                    end else begin
                        r = exp_q.pop_front();
                        chk("rsp_miss", 32'(rsp_miss), 32'(r.miss));
                        chk("rsp_type", 32'(rsp_type), 32'(r.typ));
                        chk("const_12", 32'(const_12), 32'(r.c12));
                        chk("const_20", 32'(const_20), 32'(r.c20));
                        chk("const_32", const_32, r.c32);
                    end
                end else begin
                    if (exp_q.size() > 0) begin
                        chk("missing_rsp_valid", 32'(rsp_valid), 32'd1);
                        void'(exp_q.pop_front());
                    end
                    chk("hold_miss", 32'(rsp_miss), 32'(exp_hold.miss));
                    chk("hold_type", 32'(rsp_type), 32'(exp_hold.typ));
                    chk("hold_c12", 32'(const_12), 32'(exp_hold.c12));
                    chk("hold_c20", 32'(const_20), 32'(exp_hold.c20));
                    chk("hold_c32", const_32, exp_hold.c32);
                end
            end
        end
    end

    initial begin
        int          sel;
        logic [31:0] a;
        checks    = 0;
        failures  = 0;
        started   = 1'b0;
        init_left = DEPTH;
        m_ready   = 1'b0;
        m_hit     = 0;
        m_miss    = 0;
        pend      = 1'b0;
        exp_hold  = '0;
        reset     = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        wr_type   = '0;
        req_valid = 1'b0;
        inst_add  = '0;
        cnt_clr   = 1'b0;

        repeat (3) step(0, 1, 3, 32'h123, 2'd0, 1, 32'd12, 0);
        // INIT: writes and requests must be ignored
        for (int i = 0; i < DEPTH; i++)
            step(1, 1, int'($urandom % DEPTH), $urandom, 2'($urandom), 1,
                 32'(($urandom % DEPTH) * 4), 0);

        rq(32'd0); idle(); idle();
        wr(10, 32'h00000FFF, 2'd0); rq(32'd40); idle();
        wr(23, 32'h0000007B, 2'd1); rq(32'd92);
        wr(35, 32'h000000F6, 2'd2); rq(32'd140); idle();
        rq(32'd42); rq(32'd256); idle();
        step(1, 1, 5, 32'h14, 2'd0, 1, 32'd20, 0);
        step(1, 0, 0, 32'd0, 2'd0, 0, 32'd0, 1);
        idle();
        wr(7, 32'hFFF80000, 2'd1); wr(8, 32'h800, 2'd0); wr(9, 32'hDEADBEEF, 2'd3);
        rq(32'd28); rq(32'd32); rq(32'd36); idle();

        // reset with a request in flight, then again partway through INIT
        rq(32'd40);
        step(0, 0, 0, 32'd0, 2'd0, 1, 32'd40, 0);
        step(0, 0, 0, 32'd0, 2'd0, 0, 32'd0, 0);
        repeat (20) idle();
        step(0, 0, 0, 32'd0, 2'd0, 0, 32'd0, 0);
        repeat (DEPTH) idle();
        rq(32'd40); rq(32'd92); rq(32'd140); rq(32'd20); idle();

        for (int n = 0; n < 2000; n++) begin
            sel = int'($urandom % 10);
            if (sel < 8)      a = 32'(($urandom % 72) * 4);
            else if (sel < 9) a = 32'(($urandom % 300));
            else              a = $urandom;
            step(($urandom % 400) != 0, ($urandom % 10) < 4, int'($urandom % DEPTH),
                 $urandom, 2'($urandom), ($urandom % 10) < 7, a, ($urandom % 50) == 0);
        end

        repeat (4) idle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
